// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Purpose  : Iterative 1-bit-per-cycle MULT/MULTU/DIV/DIVU with HI/LO registers
//  Revision : 1.0  initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             write_hi,
    input  logic             write_lo,
    input  logic [WIDTH-1:0] move_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                c_cnt_w   = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(WIDTH - 1);
    localparam logic [1:0]        c_st_idle = 2'd0;
    localparam logic [1:0]        c_st_prep = 2'd1;
    localparam logic [1:0]        c_st_run  = 2'd2;
    localparam logic [1:0]        c_st_fix  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;

    logic               w_signed;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH:0]     w_mul_sum, w_div_trial;
    logic [2*WIDTH-1:0] w_mul_step, w_div_step, w_prod_neg;
    logic [WIDTH-1:0]   w_quot_neg, w_rem_neg;

    // op[0]=0 selects the signed flavour (MULT/DIV); op[1]=1 selects divide
    assign w_signed = ~op_q[0];
    assign w_mag_a  = (w_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign w_mag_b  = (w_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    // acc = {partial product high half, remaining multiplier bits}
    assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
    assign w_mul_step = {w_mul_sum, acc_q[WIDTH-1:1]};

    // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    assign w_div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
    assign w_div_step  = w_div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                            : {w_div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign w_prod_neg = -acc_q;
    assign w_quot_neg = -acc_q[WIDTH-1:0];
    assign w_rem_neg  = -acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        count_d   = count_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            c_st_idle: begin
                if (write_hi) hi_d = move_data;
                if (write_lo) lo_d = move_data;
                if (start) begin
                    op_d    = op;
                    a_d     = operand_a;
                    b_d     = operand_b;
                    state_d = c_st_prep;
                end
            end
            c_st_prep: begin
                a_d       = w_mag_a;
                b_d       = w_mag_b;
                neg_res_d = w_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_rem_d = w_signed && a_q[WIDTH-1];
                count_d   = '0;
                acc_d     = op_q[1] ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
                state_d   = c_st_run;
            end
            c_st_run: begin
                acc_d   = op_q[1] ? w_div_step : w_mul_step;
                count_d = count_q + 1'b1;
                if (count_q == c_last) state_d = c_st_fix;
            end
            default: begin
                if (op_q[1]) begin
                    // A zero divisor leaves the dividend magnitude as remainder; re-signing restores operand_a
                    hi_d = neg_rem_q ? w_rem_neg : acc_q[2*WIDTH-1:WIDTH];
                    lo_d = (b_q == {WIDTH{1'b0}}) ? {WIDTH{1'b1}}
                         : (neg_res_q ? w_quot_neg : acc_q[WIDTH-1:0]);
                end else begin
                    {hi_d, lo_d} = neg_res_q ? w_prod_neg : acc_q;
                end
                done_d  = 1'b1;
                state_d = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= c_st_idle;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != c_st_idle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_unit
//  Purpose  : Vector table, hand-written handshake sequences and random ops
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clock, reset, start, write_hi, write_lo, busy, done;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b, move_data, hi, lo;

    int n_vec = 0;
    int n_mis = 0;

    int          got_lat, got_busy, dn;
    logic        hold_bad, busy_at_done;
    logic [31:0] first_hi, first_lo, got_hi, got_lo, eh, el;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t tbl[10];

    mult_div_unit #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .write_hi  (write_hi),
        .write_lo  (write_lo),
        .move_data (move_data),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h required %08h", name, act, exp);
        end
    endtask

    // Reference behaviour straight from the arithmetic definitions
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] rh, output logic [31:0] rl);
        longint      p;
        logic [63:0] u;
        int          sa, sb;
        sa = a;
        sb = b;
        rh = '0;
        rl = '0;
        case (o)
            2'd0: begin p = longint'(sa) * longint'(sb); {rh, rl} = p; end
            2'd1: begin u = {32'b0, a} * {32'b0, b}; {rh, rl} = u; end
            2'd2: begin
                if (b == 0) begin rl = '1; rh = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin rl = a; rh = '0; end
                else begin rl = sa / sb; rh = sa % sb; end
            end
            default: begin
                if (b == 0) begin rl = '1; rh = a; end
                else begin rl = a / b; rh = a % b; end
            end
        endcase
    endfunction

    task automatic kick(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
    endtask

    // Called at a negedge right after kick(); returns at the negedge where done is seen
    task automatic wait_done();
        @(negedge clock);
        start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
        operand_a = $urandom; operand_b = $urandom;
        first_hi = hi; first_lo = lo;
        got_lat = 0; got_busy = 0; hold_bad = 1'b0; busy_at_done = 1'b1;
        got_hi = 'x; got_lo = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (done) begin
                got_lat = c; got_hi = hi; got_lo = lo; busy_at_done = busy;
                break;
            end
            if (busy) got_busy++;
            if (hi !== first_hi || lo !== first_lo) hold_bad = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0;
        write_hi = 1'b0; write_lo = 1'b0; move_data = '0;

        tbl[0] = '{2'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        tbl[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[2] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        tbl[3] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[4] = '{2'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
        tbl[5] = '{2'd3, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
        tbl[6] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[7] = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        tbl[8] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        tbl[9] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);

        // MTHI / MTLO while idle
        write_hi = 1'b1; move_data = 32'h1234_5678;
        @(negedge clock);
        write_hi = 1'b0; write_lo = 1'b1; move_data = 32'h9ABC_DEF0;
        @(negedge clock);
        write_lo = 1'b0;
        check("mthi idle", hi, 32'h1234_5678);
        check("mtlo idle", lo, 32'h9ABC_DEF0);

        // Latency, busy window and hi/lo hold on the first spec example
        kick(2'd0, 32'h7, 32'hFFFF_FFFD);
        wait_done();
        check("t1 latency", 32'(got_lat), 32'd34);
        check("t1 busy cycles", 32'(got_busy), 32'd33);
        check("t1 busy at done", {31'b0, busy_at_done}, 32'd0);
        check("t1 hold", {31'b0, hold_bad}, 32'd0);
        check("t1 hi", got_hi, 32'hFFFF_FFFF);
        check("t1 lo", got_lo, 32'hFFFF_FFEB);
        @(negedge clock);
        check("t1 done width", {31'b0, done}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            kick(tbl[i].op, tbl[i].a, tbl[i].b);
            wait_done();
            check($sformatf("tbl%0d hi", i), got_hi, tbl[i].hi);
            check($sformatf("tbl%0d lo", i), got_lo, tbl[i].lo);
            check($sformatf("tbl%0d lat", i), 32'(got_lat), 32'd34);
        end

        // Start accepted in the same cycle that done is high
        kick(2'd1, 32'd6, 32'd7);
        wait_done();
        kick(2'd3, 32'd50, 32'd7);
        wait_done();
        check("b2b lat", 32'(got_lat), 32'd34);
        check("b2b hi", got_hi, 32'd1);
        check("b2b lo", got_lo, 32'd7);

        // MTLO in the launch cycle lands, then the result overwrites it
        kick(2'd1, 32'd2, 32'd2);
        write_lo = 1'b1; move_data = 32'h0000_DEAD;
        wait_done();
        check("move+start lo", first_lo, 32'h0000_DEAD);
        check("move+start result", got_lo, 32'd4);

        // start and MTHI while busy are both ignored
        kick(2'd0, 32'd3, 32'd5);
        @(negedge clock);
        start = 1'b0;
        dn = 0; got_hi = 'x; got_lo = 'x;
        for (int c = 2; c <= 80; c++) begin
            @(negedge clock);
            if (done) begin dn++; got_hi = hi; got_lo = lo; end
            start = 1'b0; write_hi = 1'b0;
            if (c == 5) kick(2'd3, 32'd9, 32'd3);
            if (c == 6) begin write_hi = 1'b1; move_data = 32'h0000_00AA; end
        end
        check("t5 done count", 32'(dn), 32'd1);
        check("t5 hi", got_hi, 32'd0);
        check("t5 lo", got_lo, 32'd15);
        check("t5 hi final", hi, 32'd0);

        // Reset mid-divide aborts the op
        kick(2'd2, 32'd100, 32'd7);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done) dn++;
        end
        check("abort no done", 32'(dn), 32'd0);
        kick(2'd1, 32'd2, 32'd3);
        wait_done();
        check("after abort lat", 32'(got_lat), 32'd34);
        check("after abort lo", got_lo, 32'd6);
        check("after abort hi", got_hi, 32'd0);

        // Randomized ops against the arithmetic model
        for (int i = 0; i < 25; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: begin ra = $urandom_range(0, 200); rb = $urandom_range(1, 20); end
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            model(ro, ra, rb, eh, el);
            kick(ro, ra, rb);
            wait_done();
            check($sformatf("rnd%0d op%0d %08h,%08h hi", i, ro, ra, rb), got_hi, eh);
            check($sformatf("rnd%0d op%0d %08h,%08h lo", i, ro, ra, rb), got_lo, el);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
